mem_nrd_1wr: RTL and testbench
==============================

// Module: mem_nrd_1wr
// PURPOSE
//  Parametrised multi-read-port, single-write-port word memory for the FPGA core.
//  Serves instruction fetch plus NRD-1 data read channels through one shared array.
//  Reads are synchronous with a per-port valid strobe. Writes take per-byte strobes.
//  A post-reset clear sequencer zeroes the array before any access is accepted.
// PARAMETERS
//  DATA_W  16          word width in bits; must be a multiple of 8
//  ADDR_W  8           word-address width
//  DEPTH   1<<ADDR_W   number of words; may be less than 2**ADDR_W
//  NRD     2           number of read ports; port 0 is instruction fetch
// PORTS
//  clk     in   1            clock; all state updates on posedge
//  rst_n   in   1            asynchronous, active-low reset
//  ready   out  1            1 = clear done, accesses accepted
//  ren     in   NRD          per-port read request
//  raddr   in   NRD*ADDR_W   read addresses; port i uses [i*ADDR_W +: ADDR_W]
//  rdata   out  NRD*DATA_W   read data; port i uses [i*DATA_W +: DATA_W]
//  rvalid  out  NRD          one-cycle pulse: rdata of port i updated this cycle
//  rerr    out  NRD          parity error flag qualified by rvalid (see CONFIGURATION)
//  wen     in   1            write enable
//  waddr   in   ADDR_W       write word address
//  wstrb   in   DATA_W/8     byte enables; bit b covers wdata[8b+7:8b]
//  wdata   in   DATA_W       write data
// BEHAVIOUR
//  Reset (async, rst_n=0): ready=0, rvalid=0, rdata=0, rerr=0, clr_cnt=0, state=CLEAR.
//  Array contents are not reset directly. The CLEAR state zeroes them.
//  FSM states: CLEAR and READY.
//   CLEAR: writes 0 to data[clr_cnt], then increments clr_cnt.
//     After DEPTH cycles (last address DEPTH-1), moves to READY.
//   READY: terminal state. Left only by reset.
//  ready=1 exactly in READY. In CLEAR, ren/wen are ignored and rvalid stays 0.
//  Read: ren[i]=1 at edge N with raddr_i.
//   Edge N+1: rdata_i = data[raddr_i]; rvalid[i]=1 for that cycle only.
//  rdata_i holds its last value while ren[i]=0. Ports are fully independent.
//  Write: wen=1 at edge N updates only the strobed bytes of data[waddr].
//   wstrb=0 writes nothing.
//  Read/write same address, same edge: write-first.
//   The read returns old word merged with wdata on strobed bytes.
//  Out of range (address >= DEPTH): write dropped; read returns 0 with rvalid=1.
//  Several ports reading one address return the same data. No arbitration, no stalls.
//  rst_n asserted mid-CLEAR: restarts from clr_cnt=0.
//   Clear always completes DEPTH cycles after the last deassertion.
//  Simulation: array may be preloaded with $readmemh("init_file.mif").
//   CLEAR overwrites the preload unless the TB forces state=READY at time 0.
// CONFIGURATION
//  MEM_PARITY_EN defined: one even-parity bit stored per byte.
//   Computed on write and on clear; clear writes parity 0.
//   Checked on read: rerr[i]=1 with rvalid[i] if any parity bit of the returned word mismatches.
//   Write-first merged data and out-of-range reads never flag.
//  MEM_PARITY_EN undefined: no parity storage; rerr tied to 0.
// TESTING
//  Reset, DEPTH=256: ready=0 for exactly 256 cycles, then 1.
//   Every read after that returns 0x0000.
//  wen, waddr=0x10, wdata=0xBEEF, wstrb=2'b11; next cycle ren[1], raddr=0x10
//   -> following cycle rdata_1=0xBEEF, rvalid[1]=1 for one cycle.
//  Write 0x1234 to addr 5, then wstrb=2'b01 with wdata=0xAACD, plus same-edge ren[0] at addr 5
//   -> rdata_0=0x12CD (write-first merge).
//  ren[0] at 0x20 and ren[1] at 0x20 on the same edge
//   -> both ports return identical data; raddr >= DEPTH (DEPTH=200) returns 0.
//  rst_n pulse at clear cycle 100
//   -> ready rises 256 cycles after release; wen during CLEAR leaves the array all-zero.
//  MEM_PARITY_EN: force-flip stored bit 3 of addr 7, then read it
//   -> rerr=1 with rvalid. Without the macro, rerr is always 0.

Source files
------------

// File: rtl/mem_nrd_1wr_if.sv
// Bus bundle for mem_nrd_1wr: NRD synchronous read channels plus one byte-strobed write channel.
interface mem_nrd_1wr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NRD    = 2
);
  logic                    ready;
  logic [NRD-1:0]          ren;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic [NRD-1:0]          rvalid;
  logic [NRD-1:0]          rerr;
  logic                    wen;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W/8-1:0]     wstrb;
  logic [DATA_W-1:0]       wdata;

  modport master (
    input  ready, rdata, rvalid, rerr,
    output ren, raddr, wen, waddr, wstrb, wdata
  );

  modport slave (
    output ready, rdata, rvalid, rerr,
    input  ren, raddr, wen, waddr, wstrb, wdata
  );
endinterface

// File: rtl/mem_nrd_1wr.sv
// Multi-read / single-write word memory; array is zeroed by a clear sequencer after reset.
// Define MEM_PARITY_EN to store one even-parity bit per byte and flag mismatches on read.
module mem_nrd_1wr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int NRD    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_nrd_1wr_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_c, clr_en_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] wmask_c, wr_word_c;
  logic              wr_hit_c;

  logic [DATA_W-1:0] rd_word_d [NRD];
  logic [NRD-1:0]    rvalid_d;
  logic [DATA_W-1:0] rdata_q [NRD];
  logic [NRD-1:0]    rvalid_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

`ifdef MEM_PARITY_EN
  logic [NB-1:0]  par_q [DEPTH];
  logic [NB-1:0]  wr_par_c;
  logic [NRD-1:0] rd_err_d, rerr_q;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction
`endif

  // Clear sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = S_READY;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready_c  = (state_q == S_READY);
    clr_en_c = (state_q == S_CLEAR);
  end

  // Write path: merged word is shared with same-address reads (write-first)
  always_comb begin
    wmask_c = '0;
    for (int b = 0; b < NB; b++) wmask_c[8*b +: 8] = {8{bus.wstrb[b]}};
    wr_hit_c  = ready_c && bus.wen && in_range(bus.waddr);
    wr_word_c = (mem_q[bus.waddr] & ~wmask_c) | (bus.wdata & wmask_c);
`ifdef MEM_PARITY_EN
    wr_par_c  = (par_q[bus.waddr] & ~bus.wstrb) | (byte_par(bus.wdata) & bus.wstrb);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr_en_c) begin
      mem_q[clr_cnt_q] <= '0;
`ifdef MEM_PARITY_EN
      par_q[clr_cnt_q] <= '0;
`endif
    end else if (wr_hit_c) begin
      mem_q[bus.waddr] <= wr_word_c;
`ifdef MEM_PARITY_EN
      par_q[bus.waddr] <= wr_par_c;
`endif
    end
  end

  // Read path: each port independent, out-of-range reads return zero
  always_comb begin
    rd_word_d = '{default: '0};
`ifdef MEM_PARITY_EN
    rd_err_d  = '0;
`endif
    for (int i = 0; i < NRD; i++) begin
      if (in_range(bus.raddr[i*ADDR_W +: ADDR_W])) begin
        if (wr_hit_c && (bus.waddr == bus.raddr[i*ADDR_W +: ADDR_W])) begin
          rd_word_d[i] = wr_word_c;
        end else begin
          rd_word_d[i] = mem_q[bus.raddr[i*ADDR_W +: ADDR_W]];
`ifdef MEM_PARITY_EN
          rd_err_d[i]  = |(byte_par(mem_q[bus.raddr[i*ADDR_W +: ADDR_W]]) ^
                           par_q[bus.raddr[i*ADDR_W +: ADDR_W]]);
`endif
        end
      end
    end
    rvalid_d = bus.ren & {NRD{ready_c}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      for (int i = 0; i < NRD; i++) rdata_q[i] <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NRD; i++) begin
        if (rvalid_d[i]) rdata_q[i] <= rd_word_d[i];
      end
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rerr_q <= '0;
    else        rerr_q <= rd_err_d & rvalid_d;
  end
`endif

  always_comb begin
    bus.ready  = ready_c;
    bus.rvalid = rvalid_q;
    bus.rdata  = '0;
    for (int i = 0; i < NRD; i++) bus.rdata[i*DATA_W +: DATA_W] = rdata_q[i];
`ifdef MEM_PARITY_EN
    bus.rerr   = rerr_q;
`else
    bus.rerr   = '0;
`endif
  end
endmodule

// File: tb/tb_mem_nrd_1wr.sv
// Directed bench for mem_nrd_1wr: a DEPTH=256 instance for the main behaviour and a
// DEPTH=200 instance for clear length and out-of-range accesses.
module tb_mem_nrd_1wr;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_nrd_1wr_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(N)) bus_a ();
  mem_nrd_1wr_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(N)) bus_b ();

  mem_nrd_1wr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .NRD(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mem_nrd_1wr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .NRD(N)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
    bus_a.wen = 1'b1; bus_a.waddr = a; bus_a.wstrb = s; bus_a.wdata = d;
    tick();
    bus_a.wen = 1'b0;
  endtask

  task automatic rd_a(input logic [N-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus_a.ren = en; bus_a.raddr = {a1, a0};
    tick();
    bus_a.ren = '0;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
    bus_b.wen = 1'b1; bus_b.waddr = a; bus_b.wstrb = s; bus_b.wdata = d;
    tick();
    bus_b.wen = 1'b0;
  endtask

  task automatic rd_b(input logic [N-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus_b.ren = en; bus_b.raddr = {a1, a0};
    tick();
    bus_b.ren = '0;
  endtask

  initial begin
    int  cnt_a, cnt_b;
    bit  done_a, done_b;
    bit  saw_vld;

    bus_a.ren = '0; bus_a.raddr = '0; bus_a.wen = 1'b0;
    bus_a.waddr = '0; bus_a.wstrb = '0; bus_a.wdata = '0;
    bus_b.ren = '0; bus_b.raddr = '0; bus_b.wen = 1'b0;
    bus_b.waddr = '0; bus_b.wstrb = '0; bus_b.wdata = '0;

    repeat (3) tick();
    chk("rst_ready",  32'(bus_a.ready),  32'h0);
    chk("rst_rvalid", 32'(bus_a.rvalid), 32'h0);
    chk("rst_rdata",  32'(bus_a.rdata),  32'h0);
    chk("rst_rerr",   32'(bus_a.rerr),   32'h0);

    // Writes and reads attempted throughout CLEAR must have no effect
    rst_n = 1'b1;
    bus_a.wen = 1'b1; bus_a.waddr = 8'h03; bus_a.wstrb = 2'b11; bus_a.wdata = 16'hFFFF;
    bus_a.ren = 2'b11; bus_a.raddr = {8'h03, 8'h03};
    saw_vld = 1'b0;
    repeat (100) begin
      tick();
      saw_vld |= |bus_a.rvalid;
    end
    chk("clear100_ready", 32'(bus_a.ready), 32'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0; done_a = 1'b0; done_b = 1'b0;
    for (int k = 1; k <= 400 && !(done_a && done_b); k++) begin
      tick();
      if (!done_a) saw_vld |= |bus_a.rvalid;
      if (bus_a.ready && !done_a) begin
        done_a = 1'b1; cnt_a = k;
        bus_a.wen = 1'b0; bus_a.ren = '0;
      end
      if (bus_b.ready && !done_b) begin
        done_b = 1'b1; cnt_b = k;
      end
    end
    chk("clear_len_256", 32'(cnt_a), 32'd256);
    chk("clear_len_200", 32'(cnt_b), 32'd200);
    chk("clear_no_rvalid", 32'(saw_vld), 32'h0);

    rd_a(2'b11, 8'h03, 8'hFF);
    chk("zero_p0_a03", 32'(bus_a.rdata[15:0]),  32'h0);
    chk("zero_p1_aFF", 32'(bus_a.rdata[31:16]), 32'h0);
    chk("zero_rvalid", 32'(bus_a.rvalid), 32'h3);
    rd_a(2'b01, 8'h00, 8'h00);
    chk("zero_p0_a00", 32'(bus_a.rdata[15:0]), 32'h0);

    wr_a(8'h10, 2'b11, 16'hBEEF);
    rd_a(2'b10, 8'h00, 8'h10);
    chk("beef_rdata1",  32'(bus_a.rdata[31:16]), 32'hBEEF);
    chk("beef_rvalid",  32'(bus_a.rvalid), 32'h2);
    tick();
    chk("beef_rvalid_drop", 32'(bus_a.rvalid), 32'h0);
    chk("beef_hold",        32'(bus_a.rdata[31:16]), 32'hBEEF);

    wr_a(8'h05, 2'b11, 16'h1234);
    bus_a.wen = 1'b1; bus_a.waddr = 8'h05; bus_a.wstrb = 2'b01; bus_a.wdata = 16'hAACD;
    bus_a.ren = 2'b01; bus_a.raddr = {8'h00, 8'h05};
    tick();
    bus_a.wen = 1'b0; bus_a.ren = '0;
    chk("wfirst_merge", 32'(bus_a.rdata[15:0]), 32'h12CD);
    chk("wfirst_rerr",  32'(bus_a.rerr), 32'h0);
    rd_a(2'b01, 8'h05, 8'h00);
    chk("merge_stored", 32'(bus_a.rdata[15:0]), 32'h12CD);

    wr_a(8'h05, 2'b00, 16'hFFFF);
    rd_a(2'b01, 8'h05, 8'h00);
    chk("strb0_nowrite", 32'(bus_a.rdata[15:0]), 32'h12CD);
    wr_a(8'h05, 2'b10, 16'h7799);
    rd_a(2'b10, 8'h00, 8'h05);
    chk("strb_hi_byte", 32'(bus_a.rdata[31:16]), 32'h77CD);

    wr_a(8'h20, 2'b11, 16'hA55A);
    rd_a(2'b11, 8'h20, 8'h20);
    chk("dual_p0", 32'(bus_a.rdata[15:0]),  32'hA55A);
    chk("dual_p1", 32'(bus_a.rdata[31:16]), 32'hA55A);
    chk("dual_rvalid", 32'(bus_a.rvalid), 32'h3);

    wr_a(8'h07, 2'b11, 16'h0F0F);
`ifdef MEM_PARITY_EN
    dut.mem_q[7][3] = ~dut.mem_q[7][3];
    rd_a(2'b01, 8'h07, 8'h00);
    chk("par_rdata", 32'(bus_a.rdata[15:0]), 32'h0F07);
    chk("par_rerr",  32'(bus_a.rerr), 32'h1);
    chk("par_rvalid", 32'(bus_a.rvalid), 32'h1);
    tick();
    chk("par_rerr_drop", 32'(bus_a.rerr), 32'h0);
`else
    rd_a(2'b01, 8'h07, 8'h00);
    chk("nopar_rdata", 32'(bus_a.rdata[15:0]), 32'h0F0F);
    chk("nopar_rerr",  32'(bus_a.rerr), 32'h0);
`endif

    wr_b(8'd199, 2'b11, 16'hC0DE);
    wr_b(8'd200, 2'b11, 16'hFFFF);
    rd_b(2'b11, 8'd199, 8'd200);
    chk("b_last_addr", 32'(bus_b.rdata[15:0]),  32'hC0DE);
    chk("b_oor_zero",  32'(bus_b.rdata[31:16]), 32'h0);
    chk("b_oor_rvalid", 32'(bus_b.rvalid), 32'h3);
    chk("b_oor_rerr",   32'(bus_b.rerr), 32'h0);
    rd_b(2'b01, 8'hFF, 8'h00);
    chk("b_oor_ff", 32'(bus_b.rdata[15:0]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
